// File: rtl/conv_pkg.sv
// Shared types and constants for the conv_net pooling stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default frame geometry, pixel_t, pool_state_e, pooling-window constants, width helper.
package conv_pkg;

  // Default frame geometry of the conv_net feature map after ReLU.
  localparam int BITWIDTH    = 8;
  localparam int DATACHANNEL = 3;
  localparam int DATAHEIGHT  = 28;
  localparam int DATAWIDTH   = 28;

  // Pooling window edge and the resulting pooled row length.
  localparam int POOL_K     = 2;
  localparam int POOL_OUT_W = DATAWIDTH / POOL_K;

  typedef logic signed [BITWIDTH-1:0] pixel_t;

  // Row parity of the input stream: even rows fill the line buffer,
  // odd rows close the 2x2 windows.
  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } pool_state_e;

  // Counter/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Line buffer of vertical partial maxima, one entry per pooled column.
// Latency: write on the clock edge, read combinationally (same-cycle).
// Backpressure: none; the owner only writes on accepted beats.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr/rd_data async read port.
module pool_linebuf
  import conv_pkg::*;
#(
  parameter int width = BITWIDTH,
  parameter int depth = POOL_OUT_W,
  parameter int aw    = clog2_min1(POOL_OUT_W)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [aw-1:0]    wr_addr,
  input  logic [width-1:0] wr_data,
  input  logic [aw-1:0]    rd_addr,
  output logic [width-1:0] rd_data
);

  // Contents are only ever read after being written in the same frame row
  // pair, so no reset is needed.
  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-ordered (ch,row,col) pixel stream.
// Latency: pooled pixel is valid 1 cycle after the edge accepting the window's last pixel.
// Backpressure: single output register; in_ready = !out_valid || out_ready, so input stalls only while a result waits.
// Ports: clk, rst_n (async, active low), flush (sync abort);
//        in_data/in_valid/in_ready input stream; out_data/out_valid/out_ready/out_last pooled stream.
module maxpool2x2_stream
  import conv_pkg::*;
#(
  parameter int bitwidth    = BITWIDTH,
  parameter int datachannel = DATACHANNEL,
  parameter int dataheight  = DATAHEIGHT,
  parameter int datawidth   = DATAWIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [bitwidth-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [bitwidth-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam int CW       = clog2_min1(datawidth);
  localparam int RWD      = clog2_min1(dataheight);
  localparam int CHW      = clog2_min1(datachannel);
  localparam int LB_DEPTH = datawidth / POOL_K;
  localparam int AW       = clog2_min1(LB_DEPTH);

  localparam logic [CW-1:0]  COL_LAST = CW'(datawidth - 1);
  localparam logic [RWD-1:0] ROW_LAST = RWD'(dataheight - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(datachannel - 1);

  // Odd dimensions would leave a partial window at every row/frame end.
  if ((dataheight % POOL_K) != 0 || (datawidth % POOL_K) != 0 ||
      dataheight < POOL_K || datawidth < POOL_K) begin : g_dim_check
    $error("maxpool2x2_stream: dataheight and datawidth must be even and >= 2");
  end

  typedef logic signed [bitwidth-1:0] pix_t;

  function automatic pix_t smax(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  pool_state_e    state_q, state_d;
  logic [CW-1:0]  col_q;
  logic [RWD-1:0] row_q;
  logic [CHW-1:0] ch_q;

  pix_t px, hmax_q, pair_max, win_max, lb_rdata;
  logic accept, pop;
  logic col_odd, col_end, row_end, ch_end, frame_end;
  logic lb_we, res_load;
  logic [AW-1:0] lb_addr;

  assign in_ready = !out_valid || out_ready;
  // Flush wins over a simultaneous beat: the beat is dropped.
  assign accept   = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready;

  assign px        = $signed(in_data);
  assign col_odd   = col_q[0];
  assign col_end   = (col_q == COL_LAST);
  assign row_end   = (row_q == ROW_LAST);
  assign ch_end    = (ch_q == CH_LAST);
  assign frame_end = ch_end && row_end && col_end;

  // Horizontal pair max on odd columns, then vertical max against the
  // partial maximum stored while streaming the even row above.
  assign pair_max = smax(hmax_q, px);
  assign win_max  = smax(lb_rdata, pair_max);
  assign lb_addr  = AW'(col_q >> 1);

  // Raster position counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else if (flush) begin
      col_q <= '0;
      row_q <= '0;
      ch_q  <= '0;
    end else if (accept) begin
      if (col_end) begin
        col_q <= '0;
        if (row_end) begin
          row_q <= '0;
          ch_q  <= ch_end ? '0 : ch_q + 1'b1;
        end else begin
          row_q <= row_q + 1'b1;
        end
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Left pixel of the current horizontal pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hmax_q <= '0;
    end else if (accept && !col_odd) begin
      hmax_q <= px;
    end
  end

  // Row-parity FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ROW_EVEN;
    end else if (flush) begin
      state_q <= ROW_EVEN;
    end else begin
      state_q <= state_d;
    end
  end

  // Row-parity FSM: next state flips on the last column of each row.
  always_comb begin
    state_d = state_q;
    if (accept && col_end) begin
      state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
    end
  end

  // Row-parity FSM: outputs. Even rows park the pair max, odd rows finish
  // the window and load the output register.
  always_comb begin
    lb_we    = 1'b0;
    res_load = 1'b0;
    if (accept && col_odd) begin
      if (state_q == ROW_EVEN) begin
        lb_we = 1'b1;
      end else begin
        res_load = 1'b1;
      end
    end
  end

  pool_linebuf #(
    .width (bitwidth),
    .depth (LB_DEPTH),
    .aw    (AW)
  ) u_linebuf (
    .clk     (clk),
    .wr_en   (lb_we),
    .wr_addr (lb_addr),
    .wr_data (pair_max),
    .rd_addr (lb_addr),
    .rd_data (lb_rdata)
  );

  // Output register. res_load can only fire when in_ready is high, so a
  // stalled result is never overwritten; load-with-pop reloads bubble-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (res_load) begin
      out_data  <= win_max;
      out_valid <= 1'b1;
      out_last  <= frame_end;
    end else if (pop) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream with three geometries behind one stream mux.
// Latency: checks result timing one cycle after the window-closing accept.
// Backpressure: exercises output stalls, flush and async reset mid-frame.
module tb_maxpool2x2_stream;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic [1:0] sel;

  logic [2:0] rdy_v, vld_v, lst_v;
  logic [7:0] dat_v [3];

  logic       in_ready, out_valid, out_last;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  assign in_ready  = rdy_v[sel];
  assign out_valid = vld_v[sel];
  assign out_last  = lst_v[sel];
  assign out_data  = dat_v[sel];

  // A: 1x4x4, B: 2x4x4, C: default 3x28x28.
  maxpool2x2_stream #(.bitwidth(8), .datachannel(1), .dataheight(4), .datawidth(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid && (sel == 2'd0)), .in_ready(rdy_v[0]),
    .out_data(dat_v[0]), .out_valid(vld_v[0]), .out_ready(out_ready), .out_last(lst_v[0]));

  maxpool2x2_stream #(.bitwidth(8), .datachannel(2), .dataheight(4), .datawidth(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid && (sel == 2'd1)), .in_ready(rdy_v[1]),
    .out_data(dat_v[1]), .out_valid(vld_v[1]), .out_ready(out_ready), .out_last(lst_v[1]));

  maxpool2x2_stream u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid && (sel == 2'd2)), .in_ready(rdy_v[2]),
    .out_data(dat_v[2]), .out_valid(vld_v[2]), .out_ready(out_ready), .out_last(lst_v[2]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] in_q  [$];
  logic [7:0] out_q [$];
  logic       out_lq[$];
  int         out_cq[$];
  logic [7:0] exp_d [$];
  logic       exp_l [$];
  int         acc_cyc [8192];

  logic       stalled = 1'b0;
  logic [7:0] st_d;
  logic       st_l;
  logic       saw_low = 1'b0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_vld", out_valid, 1);
        chk("stall_dat", out_data, st_d);
        chk("stall_lst", out_last, st_l);
      end
      if (out_valid && out_ready) begin
        out_q.push_back(out_data);
        out_lq.push_back(out_last);
        out_cq.push_back(cyc);
      end
      if (!in_ready) saw_low = 1'b1;
      stalled = out_valid && !out_ready && !flush;
      st_d    = out_data;
      st_l    = out_last;
    end
  end

  task automatic clear_all();
    in_q.delete(); out_q.delete(); out_lq.delete(); out_cq.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  // Streams in_q; entered and left at posedge+1.
  task automatic drive(input int pct);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    while (idx < in_q.size() && guard < 20000) begin
      in_valid = ($urandom_range(99) < pct);
      in_data  = in_q[idx];
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    chk("drive_done", idx, in_q.size());
  endtask

  task automatic wait_outs(input int n);
    int g;
    g = 0;
    while (out_q.size() < n && g < 3000) begin
      @(posedge clk);
      g++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("out_count", out_q.size(), n);
  endtask

  task automatic cmp_outs(input string tag);
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < out_q.size()) begin
        chk({tag, "_dat"}, out_q[i], exp_d[i]);
        chk({tag, "_lst"}, out_lq[i], exp_l[i]);
      end
    end
  endtask

  // Reference: direct 2x2 window max over the raster frame at in_q[base].
  task automatic model(input int base, input int nc, input int nh, input int nw);
    for (int c = 0; c < nc; c++) begin
      for (int r = 0; r < nh / 2; r++) begin
        for (int k = 0; k < nw / 2; k++) begin
          int b;
          logic signed [7:0] m;
          b = base + c * nh * nw + 2 * r * nw + 2 * k;
          m = $signed(in_q[b]);
          if ($signed(in_q[b + 1]) > m)      m = $signed(in_q[b + 1]);
          if ($signed(in_q[b + nw]) > m)     m = $signed(in_q[b + nw]);
          if ($signed(in_q[b + nw + 1]) > m) m = $signed(in_q[b + nw + 1]);
          exp_d.push_back(m);
          exp_l.push_back((c == nc - 1) && (r == nh / 2 - 1) && (k == nw / 2 - 1));
        end
      end
    end
  endtask

  task automatic push_ramp_exp();
    for (int i = 0; i < 16; i++) in_q.push_back(8'(i));
    exp_d.push_back(8'd5);  exp_l.push_back(1'b0);
    exp_d.push_back(8'd7);  exp_l.push_back(1'b0);
    exp_d.push_back(8'd13); exp_l.push_back(1'b0);
    exp_d.push_back(8'd15); exp_l.push_back(1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pix_of [4];
    logic [7:0] sv_tab [16];
    int nl;
    logic done;

    pix_of = '{5, 7, 13, 15};
    sv_tab = '{8'hFD, 8'hF9, 8'h80, 8'h00,
               8'hFF, 8'h80, 8'h80, 8'h80,
               8'h0A, 8'h14, 8'h1E, 8'h28,
               8'hCE, 8'hC4, 8'h7F, 8'h80};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; sel = 2'd0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_vld", vld_v, 3'b000);
    chk("rst_lst", lst_v, 3'b000);
    chk("rst_rdy", rdy_v, 3'b111);
    chk("rst_dat", out_data, 8'h00);

    // Ramp 0..15 on 1x4x4, full rate
    clear_all();
    push_ramp_exp();
    drive(100);
    wait_outs(4);
    cmp_outs("ramp");
    for (int i = 0; i < 4; i++) begin
      if (i < out_cq.size()) chk("ramp_lat", out_cq[i], acc_cyc[pix_of[i]] + 1);
    end

    // Signed windows
    clear_all();
    for (int i = 0; i < 16; i++) in_q.push_back(sv_tab[i]);
    exp_d.push_back(8'hFF); exp_l.push_back(1'b0);
    exp_d.push_back(8'h00); exp_l.push_back(1'b0);
    exp_d.push_back(8'h14); exp_l.push_back(1'b0);
    exp_d.push_back(8'h7F); exp_l.push_back(1'b1);
    drive(60);
    wait_outs(4);
    cmp_outs("signed");

    // Backpressure: out_ready low for the first 10 cycles
    clear_all();
    push_ramp_exp();
    saw_low = 1'b0;
    fork
      drive(100);
      begin
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_outs(4);
    cmp_outs("bp");
    chk("bp_inrdy_low", saw_low, 1);

    // Async reset mid-row with a stalled result
    clear_all();
    for (int i = 0; i < 6; i++) in_q.push_back(8'(i));
    out_ready = 1'b0;
    drive(100);
    chk("ar_pre_vld", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", out_valid, 0);
    chk("ar_lst", out_last, 0);
    chk("ar_rdy", in_ready, 1);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clear_all();
    push_ramp_exp();
    drive(100);
    wait_outs(4);
    cmp_outs("ar_post");

    // Flush after 37 pixels of a 2x4x4 stream, then a fresh frame
    sel = 2'd1;
    clear_all();
    for (int i = 0; i < 37; i++) in_q.push_back(8'($urandom_range(255)));
    model(0, 2, 4, 4);
    drive(80);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h7F;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_vld", out_valid, 0);
    chk("flush_lst", out_last, 0);
    @(posedge clk); #1;
    wait_outs(8);
    cmp_outs("pre_flush");
    clear_all();
    for (int i = 0; i < 32; i++) in_q.push_back(8'($urandom_range(255)));
    model(0, 2, 4, 4);
    drive(80);
    wait_outs(8);
    cmp_outs("post_flush");

    // Two back-to-back default frames, random valid and ready
    sel = 2'd2;
    clear_all();
    for (int i = 0; i < 2 * 2352; i++) in_q.push_back(8'($urandom_range(255)));
    model(0, 3, 28, 28);
    model(2352, 3, 28, 28);
    done = 1'b0;
    fork
      begin
        drive(70);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(99) < 85);
        end
        out_ready = 1'b1;
      end
    join
    wait_outs(1176);
    cmp_outs("full");
    nl = 0;
    foreach (out_lq[i]) if (out_lq[i]) nl++;
    chk("full_last_cnt", nl, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage directly downstream of the ReLU activation stage in conv_net.
- Consumes activated pixels one per beat in raster order: channel, then row, then column.
- Emits one pooled pixel per 2x2 window, in the same order, over a valid/ready handshake.
- Holds one half-width line buffer of partial maxima, so the whole feature map is never stored.

Parameters:
- bitwidth, 8, pixel width in bits; two's-complement signed.
- datachannel, 3, channels per frame.
- dataheight, 28, input rows per channel; must be even (elaboration-time check fails otherwise).
- datawidth, 28, input columns per row; must be even (same check).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the current frame.
- in_data  in  bitwidth  activated pixel.
- in_valid  in  1  in_data valid.
- in_ready  out  1  stage can accept in_data this cycle.
- out_data  out  bitwidth  pooled pixel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  with out_valid: last pooled pixel of the frame.

Interface rule (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, out_data=0, out_last=0, in_ready=1 after release.
  - col/row/ch counters=0, state=ROW_EVEN, line buffer contents don't-care.
- Accept: a beat transfers when in_valid && in_ready. Output transfers when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is a single output register with pass-through on pop. In_ready may drop only while a pooled result is stalled.
- Comparison is signed, max(a,b). Ties keep either value; values are identical anyway.
- Column parity register hmax:
  - even column: hmax <= pixel.
  - odd column: pair max m = max(hmax, pixel).
- FSM states ROW_EVEN and ROW_ODD:
  - ROW_EVEN, odd column: linebuf[col>>1] <= m. No output.
  - ROW_ODD, odd column: out_data <= max(linebuf[col>>1], m), out_valid <= 1. Latency is 1 cycle from the accepting edge.
  - Transition ROW_EVEN->ROW_ODD and back occurs on acceptance of column datawidth-1.
- Counter wrap:
  - col wraps at datawidth-1, incrementing row.
  - row wraps at dataheight-1, incrementing ch.
  - ch wraps at datachannel-1 to 0. The next frame starts with no idle cycle.
- out_last=1 with the result from pixel (ch=datachannel-1, row=dataheight-1, col=datawidth-1). Otherwise 0. Held with out_data while stalled.
- Stall: out_data, out_valid and out_last are stable while out_valid && !out_ready.
- Simultaneous pop and new result: the output register reloads in the same cycle with no bubble. out_valid stays 1.
- flush=1 (sync):
  - counters=0, state=ROW_EVEN, out_valid=0, out_last=0.
  - in_data that cycle is ignored. Flush dominates a simultaneous accept or pop.
- rst_n asserted mid-frame: immediate return to reset values. The partial window is discarded and no output is produced.
- Throughput: 1 input/cycle sustained when out_ready=1. Output rate is 1/4 of the input rate.
- Outputs per frame: datachannel*(dataheight/2)*(datawidth/2). Defaults give 588.

Decomposition:
- Package conv_pkg:
  - pixel_t typedef (logic signed [bitwidth-1:0]).
  - pool_state_e enum {ROW_EVEN, ROW_ODD}.
  - localparams POOL_K=2 and POOL_OUT_W=datawidth/2.
- Sub-module pool_linebuf: depth datawidth/2, 1 write port plus 1 async-read port, no reset. Holds the vertical partial maxima.
- Counters, FSM and the output register stay in the top.

Test Plan:
- Ramp, 1 channel, 4x4 input 0..15, out_ready=1 -> outputs 5,7,13,15; out_last on 15; each one cycle after the accepting edge of inputs 5,7,13,15 respectively.
- Signed values: window {-3,-7,-1,-128} -> out_data=-1 (0xFF at bitwidth 8). Window {-128,0,-128,-128} -> 0.
- Backpressure: out_ready=0 for 10 cycles while streaming a 4x4 frame -> in_ready drops after the first result. No beat lost or duplicated; output order and values match the unstalled run.
- Full default frame (3x28x28, random data, in_valid random 70%) -> exactly 588 outputs matching the reference model. out_last exactly once, on output 588. A second back-to-back frame matches as well.
- Flush after 37 accepted pixels of a 4x4 two-channel frame -> out_valid=0 next cycle. The next 32 pixels are treated as a new frame with outputs computed from scratch.
- Async reset asserted mid-row with out_valid=1 -> out_valid=0 immediately, without a clock edge. The post-reset frame output is correct.
